// File: rtl/mul_accumulator.sv
// ============================================================================
// mul_accumulator : element-wise dot-product accumulator behind the multiplier
//                   array. Optional macro ACC_SATURATE_EN clamps lanes at
//                   all-ones instead of wrapping.
// Revision 1.0    : initial release
// ============================================================================
`default_nettype none

`ifndef DIM_A
`define DIM_A 2
`endif
`ifndef DIM_C
`define DIM_C 2
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 16
`endif

module mul_accumulator #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [`DIM_C-1:0][`DIM_A-1:0][`ACC_WIDTH-1:0] in_prod,
  input  logic                                         in_valid,
  input  logic                                         in_last,
  output logic                                         in_ready,
  output logic [`DIM_C-1:0][`DIM_A-1:0][`ACC_WIDTH-1:0] out_sum,
  output logic [CNT_WIDTH-1:0]                         out_count,
  output logic                                         out_ovf,
  output logic                                         out_valid,
  input  logic                                         out_ready
);

  localparam int DC = `DIM_C;
  localparam int DA = `DIM_A;
  localparam int AW = `ACC_WIDTH;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

  state_t                          state_q, state_d;
  logic [DC-1:0][DA-1:0][AW-1:0]   acc_q, acc_d;
  logic [DC-1:0][DA-1:0][AW-1:0]   lane_sum;
  logic [CNT_WIDTH-1:0]            cnt_q, cnt_d, cnt_inc;
  logic                            ovf_q, ovf_d, ovf_new;
  logic [DC-1:0][DA-1:0][AW-1:0]   out_sum_q, out_sum_d;
  logic [CNT_WIDTH-1:0]            out_count_q, out_count_d;
  logic                            out_ovf_q, out_ovf_d;
  logic                            out_valid_q, out_valid_d;
  logic                            accept;
  logic [AW:0]                     wide;
  logic [AW-1:0]                   base;

  assign in_ready  = ~out_valid_q | out_ready;
  assign accept    = in_valid & in_ready;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;
  assign out_valid = out_valid_q;

  // In IDLE the bank is treated as zero, so the first beat simply loads.
  always_comb begin
    wide     = '0;
    base     = '0;
    lane_sum = '0;
    ovf_new  = (state_q == S_ACCUM) ? ovf_q : 1'b0;
    for (int i = 0; i < DC; i++) begin
      for (int j = 0; j < DA; j++) begin
        base    = (state_q == S_ACCUM) ? acc_q[i][j] : '0;
        wide    = {1'b0, base} + {1'b0, in_prod[i][j]};
        ovf_new = ovf_new | wide[AW];
`ifdef ACC_SATURATE_EN
        lane_sum[i][j] = wide[AW] ? {AW{1'b1}} : wide[AW-1:0];
`else
        lane_sum[i][j] = wide[AW-1:0];
`endif
      end
    end
  end

  always_comb begin
    if (state_q == S_ACCUM) begin
      cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
    end else begin
      cnt_inc = CNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (in_last) begin
        out_sum_d   = lane_sum;
        out_count_d = cnt_inc;
        out_ovf_d   = ovf_new;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
        state_d     = S_IDLE;
      end else begin
        acc_d       = lane_sum;
        cnt_d       = cnt_inc;
        ovf_d       = ovf_new;
        state_d     = S_ACCUM;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mul_accumulator.sv
// Testbench for mul_accumulator: vector table, directed corner sequences and
// a randomized run against an integer reference model.
`default_nettype none

module tb_mul_accumulator;

  localparam int DA   = 2;
  localparam int DC   = 2;
  localparam int AW   = 16;
  localparam int CW   = 3;
  localparam int NL   = DA * DC;
  localparam int CMAX = (1 << CW) - 1;
  localparam int AMAX = (1 << AW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                          rst_n;
  logic [DC-1:0][DA-1:0][AW-1:0] in_prod;
  logic                          in_valid;
  logic                          in_last;
  logic                          in_ready;
  logic [DC-1:0][DA-1:0][AW-1:0] out_sum;
  logic [CW-1:0]                 out_count;
  logic                          out_ovf;
  logic                          out_valid;
  logic                          out_ready;

  mul_accumulator #(.CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_prod   (in_prod),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: running dot product and output register as plain integers.
  int unsigned m_sum  [NL];
  int unsigned m_cnt;
  bit          m_ovf;
  bit          m_open;
  int unsigned m_osum [NL];
  int unsigned m_ocnt;
  bit          m_oovf;
  bit          m_ov;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned lane_of(input logic [DC-1:0][DA-1:0][AW-1:0] p, input int k);
    return int'(p[k / DA][k % DA]);
  endfunction

  function automatic logic [DC-1:0][DA-1:0][AW-1:0] all_lanes(input int unsigned v);
    logic [DC-1:0][DA-1:0][AW-1:0] p;
    for (int k = 0; k < NL; k++) p[k / DA][k % DA] = AW'(v);
    return p;
  endfunction

  task automatic model_reset();
    m_open = 0; m_cnt = 0; m_ovf = 0;
    m_ov = 0; m_ocnt = 0; m_oovf = 0;
    for (int k = 0; k < NL; k++) begin
      m_sum[k] = 0;
      m_osum[k] = 0;
    end
  endtask

  task automatic model_step();
    bit          acc;
    bit          nov;
    int unsigned s;
    int unsigned nsum [NL];
    int unsigned ncnt;
    if (!rst_n) begin
      model_reset();
      return;
    end
    acc = in_valid && (!m_ov || out_ready);
    if (m_ov && out_ready) m_ov = 0;
    if (!acc) return;
    nov = m_open ? m_ovf : 1'b0;
    for (int k = 0; k < NL; k++) begin
      s = (m_open ? m_sum[k] : 0) + lane_of(in_prod, k);
      if (s > AMAX) begin
        nov = 1;
`ifdef ACC_SATURATE_EN
        s = AMAX;
`else
        s = s - (AMAX + 1);
`endif
      end
      nsum[k] = s;
    end
    ncnt = m_open ? ((m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1) : 1;
    if (in_last) begin
      m_osum = nsum; m_ocnt = ncnt; m_oovf = nov; m_ov = 1; m_open = 0;
    end else begin
      m_sum = nsum; m_cnt = ncnt; m_ovf = nov; m_open = 1;
    end
  endtask

  task automatic compare_model();
    chk("model out_valid", out_valid, m_ov);
    chk("model out_count", out_count, m_ocnt);
    chk("model out_ovf", out_ovf, m_oovf);
    for (int k = 0; k < NL; k++) chk($sformatf("model out_sum[%0d]", k), lane_of(out_sum, k), m_osum[k]);
  endtask

  // One clock: check in_ready before the edge, advance model, compare after the edge.
  task automatic cycle();
    #1;
    if (rst_n) chk("in_ready", in_ready, (!m_ov || out_ready));
    model_step();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  typedef struct {
    bit          v;
    int unsigned val;
    bit          last;
    bit          ordy;
    bit          e_valid;
    int unsigned e_sum;
    int unsigned e_cnt;
  } vec_t;

  vec_t tbl [13];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; in_prod = '0;
    model_reset();

    // Reset and idle
    cycle(); cycle();
    rst_n = 1'b1;
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset out_count", out_count, 0);
    chk("reset out_ovf", out_ovf, 0);
    chk("reset out_sum", out_sum, 0);
    chk("reset in_ready", in_ready, 1);
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("idle out_valid", out_valid, 0);
    end

    // Table: 4-beat sum of 3s, then 8 back-to-back single-beat products
    tbl[0] = '{1, 3, 0, 1, 0, 0, 0};
    tbl[1] = '{1, 3, 0, 1, 0, 0, 0};
    tbl[2] = '{1, 3, 0, 1, 0, 0, 0};
    tbl[3] = '{1, 3, 1, 1, 1, 12, 4};
    for (int i = 0; i < 8; i++) tbl[4 + i] = '{1, i + 1, 1, 1, 1, i + 1, 1};
    tbl[12] = '{0, 0, 0, 1, 0, 0, 0};
    for (int i = 0; i < 13; i++) begin
      in_valid = tbl[i].v; in_prod = all_lanes(tbl[i].val);
      in_last = tbl[i].last; out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("tbl[%0d] in_ready", i), in_ready, 1);
      cycle();
      chk($sformatf("tbl[%0d] out_valid", i), out_valid, tbl[i].e_valid);
      if (tbl[i].e_valid) begin
        chk($sformatf("tbl[%0d] out_count", i), out_count, tbl[i].e_cnt);
        chk($sformatf("tbl[%0d] out_ovf", i), out_ovf, 0);
        for (int k = 0; k < NL; k++) chk($sformatf("tbl[%0d] out_sum", i), lane_of(out_sum, k), tbl[i].e_sum);
      end
    end

    // Stall: result 9 held while a non-last beat is offered
    in_valid = 1; in_prod = all_lanes(9); in_last = 1; out_ready = 0;
    cycle();
    in_prod = all_lanes(4); in_last = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall in_ready", in_ready, 0);
      cycle();
      chk("stall out_valid", out_valid, 1);
      chk("stall out_sum", lane_of(out_sum, 3), 9);
      chk("stall out_count", out_count, 1);
    end
    out_ready = 1; in_prod = all_lanes(7); in_last = 1;
    cycle();
    chk("refill out_valid", out_valid, 1);
    chk("refill out_sum", lane_of(out_sum, 0), 7);
    in_valid = 0;
    cycle();
    chk("drain out_valid", out_valid, 0);

    // Overflow in lane [0][0]
    in_valid = 1; in_last = 0; in_prod = '0; in_prod[0][0] = 16'hFFF0;
    cycle();
    in_last = 1; in_prod[0][0] = 16'h0020;
    cycle();
`ifdef ACC_SATURATE_EN
    chk("ovf out_sum[0][0]", out_sum[0][0], 16'hFFFF);
`else
    chk("ovf out_sum[0][0]", out_sum[0][0], 16'h0010);
`endif
    chk("ovf out_ovf", out_ovf, 1);
    chk("ovf other lane", out_sum[1][1], 0);
    // Sticky flag must not leak into the next sum
    in_prod = all_lanes(2);
    cycle();
    chk("ovf cleared", out_ovf, 0);

    // Beat counter saturates at all-ones
    in_last = 0; in_prod = all_lanes(1);
    for (int i = 0; i < 8; i++) cycle();
    in_last = 1;
    cycle();
    chk("sat out_count", out_count, CMAX);
    chk("sat out_sum", lane_of(out_sum, 2), 9);

    // Reset mid-sum discards the partial bank
    in_last = 0; in_prod = all_lanes(1);
    cycle(); cycle();
    rst_n = 0; in_valid = 0;
    cycle();
    chk("midrst out_valid", out_valid, 0);
    chk("midrst out_count", out_count, 0);
    rst_n = 1; in_valid = 1; in_last = 1; in_prod = all_lanes(5);
    cycle();
    chk("midrst out_sum", lane_of(out_sum, 1), 5);
    chk("midrst out_count1", out_count, 1);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_last   = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      for (int k = 0; k < NL; k++)
        in_prod[k / DA][k % DA] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(60000, AMAX))
                                                               : AW'($urandom_range(0, 2000));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
